mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares a single unified memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the pipelined MIPS core. A 3-state FSM grants one requester at a time and alternates round-robin under contention. It enforces a bounded-wait timeout and drives stall outputs that the hazard unit ORs into its existing fetch/decode stall and execute flush terms.

## Interface
- `TIMEOUT`, default 16: maximum cycles a granted access waits for `mem_ack_i` before it is aborted; legal range 2–256.
- `clk_i` in 1: clock, all state on the rising edge.
- `rst_n_i` in 1: asynchronous active-low reset.
- `if_req_i` in 1: fetch read request; held until `if_ready_o`.
- `if_addr_i` in 32: fetch byte address.
- `if_rdata_o` out 32: fetch data, valid only while `if_ready_o`.
- `if_ready_o` out 1: one-cycle completion pulse for fetch.
- `dm_req_i` in 1: data request; held until `dm_ready_o`.
- `dm_we_i` in 1: 1 = store, 0 = load.
- `dm_addr_i` in 32: data byte address.
- `dm_wdata_i` in 32: store data.
- `dm_rdata_o` out 32: load data, valid only while `dm_ready_o`.
- `dm_ready_o` out 1: one-cycle completion pulse for data.
- `mem_req_o` out 1: memory access strobe.
- `mem_we_o` out 1: memory write enable.
- `mem_addr_o` out 32: memory address.
- `mem_wdata_o` out 32: memory write data.
- `mem_rdata_i` in 32: memory read data, valid with `mem_ack_i`.
- `mem_ack_i` in 1: memory completion; ignored when `mem_req_o` = 0.
- `stall_f_o` out 1: `if_req_i & ~if_ready_o`.
- `stall_m_o` out 1: `dm_req_i & ~dm_ready_o`.
- `err_o` out 1: one-cycle pulse on timeout abort.

## Operation
- States: IDLE, IF_BUSY, DM_BUSY. `last_grant` is a 1-bit register (F/D).
- IDLE has the following transitions:
  - Only `dm_req_i` → DM_BUSY.
  - Only `if_req_i` → IF_BUSY.
  - Both → grant the side not equal to `last_grant`.
  - Neither → stay.
- On entry to a busy state, the following are registered and held constant for the whole access: `mem_req_o`=1, `mem_addr_o`, `mem_we_o` (data: `dm_we_i`; fetch: 0), `mem_wdata_o` (fetch: 0). `last_grant` is updated at the same time.
- In a busy state, `mem_ack_i`=1 completes the access:
  - The matching ready pulses and its rdata = `mem_rdata_i` in that cycle. For stores, rdata = 0.
  - Next state: the other requester's busy state if it is pending (back-to-back, `mem_req_o` stays 1 with the new address). Otherwise IDLE.
- Wait counter `wait_cnt` (width $clog2(TIMEOUT)) clears on every grant and increments each busy cycle without ack.
- Timeout abort: the busy cycle with `wait_cnt`==TIMEOUT-1 and no ack.
  - `err_o`=1, the matching ready pulses with rdata = 0, and the FSM leaves the busy state exactly as on an ack.
  - The aborted store is not retried.
- Ack and timeout in the same cycle: treated as a normal ack; `err_o`=0.
- Requester drops its request mid-access: the access still runs to ack or timeout and the ready pulse is still emitted; the requester ignores it.
- Reset (any time, including mid-access): state=IDLE, `last_grant`=F (first contention goes to data), `wait_cnt`=0. All outputs are 0 immediately (asynchronous), including `mem_req_o`.

## Timing
- Minimum access latency: request sampled in IDLE at edge N; `mem_req_o` high in cycle N+1; ack in N+1 gives ready in N+1. The requester stalls exactly 1 cycle.
- Each ready pulse is combinational from state and `mem_ack_i`. It lasts exactly one cycle per access.
- Back-to-back accesses have no IDLE bubble between them.
- A timed-out access holds `mem_req_o` for exactly TIMEOUT cycles.
- The stall outputs are combinational from their inputs and ready, with no added register stage.

## Configuration
- `MEMARB_FETCH_BUF_EN` defined:
  - Adds a one-entry fetch buffer (valid, addr, data), loaded on every successful fetch ack.
  - An `if_req_i` that matches the valid buffer address in IDLE, or in DM_BUSY, pulses `if_ready_o` in the same cycle with the buffered data. It makes no memory access and does not change `last_grant`.
  - A `dm_req_i` store whose address matches the buffer clears valid at its grant.
  - Reset and timeout clear valid.
- `MEMARB_FETCH_BUF_EN` undefined: the buffer logic is absent and every fetch goes to memory.

## Test plan
- Single fetch, addr 0x0000_0040, ack in the first busy cycle → `mem_req_o` 1 cycle, `if_ready_o` 1 cycle, `if_rdata_o`=`mem_rdata_i`=0x2008_0005, `stall_f_o` high 1 cycle.
- Both requesters asserted from reset, ack latency 2 → data granted first, then fetch back-to-back with no IDLE cycle; `last_grant` ends at F.
- Store 0xDEAD_BEEF to 0x100, ack never asserted, TIMEOUT=16 → `mem_req_o` high 16 cycles, then `err_o` and `dm_ready_o` both pulse in cycle 16 with `dm_rdata_o`=0, and the FSM returns to IDLE.
- `rst_n_i` low during cycle 2 of a fetch → `mem_req_o` drops without waiting for a clock edge; after release, a new data request is granted normally.
- With `MEMARB_FETCH_BUF_EN` defined:
  - A repeat fetch of 0x40 gives `if_ready_o` in the same cycle with no `mem_req_o`.
  - After a store to 0x40, the next fetch of 0x40 goes to memory.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and data (DM).
// Three-state FSM (IDLE / IF_BUSY / DM_BUSY), round-robin under contention,
// bounded wait of TIMEOUT cycles per access, and combinational stall outputs.
// Optional one-entry fetch buffer enabled by defining MEMARB_FETCH_BUF_EN.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        stall_f_o,
  output logic        stall_m_o,
  output logic        err_o
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic GRANT_F = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  state_t          state_q, state_d;
  logic            last_grant_q;
  logic [CW-1:0]   wait_cnt_q;
  logic            busy, timeout, done;
  logic            fetch_done, data_done;
  logic            if_want, grant_if, grant_dm;
  logic            buf_hit;
  logic [31:0]     buf_data_q;

  assign busy       = (state_q != IDLE);
  // Timeout only counts when the memory has not answered; ack wins a tie.
  assign timeout    = busy && !mem_ack_i && (wait_cnt_q == CNT_LAST);
  assign done       = busy && (mem_ack_i || timeout);
  assign fetch_done = (state_q == IF_BUSY) && done;
  assign data_done  = (state_q == DM_BUSY) && done;

`ifdef MEMARB_FETCH_BUF_EN
  logic        buf_valid_q;
  logic [31:0] buf_addr_q;
  logic [31:0] buf_addr_nx;
  logic        buf_fill, buf_kill;

  // A buffered fetch is served while the port is idle or busy with data.
  assign buf_hit     = buf_valid_q && if_req_i && (if_addr_i == buf_addr_q) &&
                       (state_q != IF_BUSY);
  assign buf_fill    = fetch_done && mem_ack_i;
  // Compare a granted store against the entry as it will be after this edge,
  // so a fill and a matching store in the same cycle leave the entry invalid.
  assign buf_addr_nx = buf_fill ? mem_addr_o : buf_addr_q;
  assign buf_kill    = timeout || (grant_dm && dm_we_i && (dm_addr_i == buf_addr_nx));

  // Fetch buffer: filled on fetch ack, invalidated by matching store or timeout.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      if (buf_fill) begin
        buf_addr_q <= mem_addr_o;
        buf_data_q <= mem_rdata_i;
      end
      if (buf_kill)      buf_valid_q <= 1'b0;
      else if (buf_fill) buf_valid_q <= 1'b1;
    end
  end

  assign if_want = if_req_i && !buf_hit;
`else
  assign buf_hit    = 1'b0;
  assign buf_data_q = '0;
  assign if_want    = if_req_i;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and grant decisions; completion hands over to a pending peer.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_req_i && (!if_want || last_grant_q == GRANT_F)) grant_dm = 1'b1;
        else if (if_want)                                     grant_if = 1'b1;
      end
      IF_BUSY: if (done) begin
        if (dm_req_i) grant_dm = 1'b1;
        else          state_d  = IDLE;
      end
      DM_BUSY: if (done) begin
        if (if_want) grant_if = 1'b1;
        else         state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (grant_dm)      state_d = DM_BUSY;
    else if (grant_if) state_d = IF_BUSY;
  end

  // Memory port registers, round-robin pointer and wait counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      last_grant_q <= GRANT_F;
      wait_cnt_q   <= '0;
    end else if (grant_dm) begin
      mem_req_o    <= 1'b1;
      mem_we_o     <= dm_we_i;
      mem_addr_o   <= dm_addr_i;
      mem_wdata_o  <= dm_wdata_i;
      last_grant_q <= GRANT_D;
      wait_cnt_q   <= '0;
    end else if (grant_if) begin
      mem_req_o    <= 1'b1;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= if_addr_i;
      mem_wdata_o  <= '0;
      last_grant_q <= GRANT_F;
      wait_cnt_q   <= '0;
    end else if (done) begin
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      wait_cnt_q   <= '0;
    end else if (busy) begin
      wait_cnt_q   <= wait_cnt_q + CW'(1);
    end
  end

  assign if_ready_o = fetch_done || buf_hit;
  assign if_rdata_o = buf_hit                  ? buf_data_q  :
                      (fetch_done && mem_ack_i) ? mem_rdata_i : '0;
  assign dm_ready_o = data_done;
  assign dm_rdata_o = (data_done && mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;
  assign err_o      = timeout;
  // Held low during reset so every output is quiet while rst_n_i is low.
  assign stall_f_o  = rst_n_i && if_req_i && !if_ready_o;
  assign stall_m_o  = rst_n_i && dm_req_i && !dm_ready_o;
endmodule
